// File: rtl/m6809_pkg.sv
// m6809_pkg: shared encodings for the 16-bit D-register sequencer and the
// 8-bit ALU it drives.
//   op16_e  : 16-bit operation select presented on op16.
//   state_e : sequencer state (IDLE -> LO -> HI -> IDLE).
//   ALU_*   : 8-bit ALU opcodes in 6809 low-nibble encoding.
package m6809_pkg;

  typedef enum logic [1:0] {
    ALU16_ADD = 2'd0,
    ALU16_SUB = 2'd1,
    ALU16_CMP = 2'd2,
    ALU16_LD  = 2'd3
  } op16_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'hb;
  localparam logic [3:0] ALU_ADC = 4'h9;
  localparam logic [3:0] ALU_SUB = 4'h0;
  localparam logic [3:0] ALU_SBC = 4'h2;
  localparam logic [3:0] ALU_LD  = 4'h6;
  localparam logic [3:0] ALU_TST = 4'hd;

endpackage

// File: rtl/m6809_alu8.sv
// m6809_alu8: combinational 8-bit ALU slice covering the opcodes the 16-bit
// sequencer issues. Carry-out is a borrow for SUB/SBC (C=1 on borrow).
// Ports:
//   a, b   in  8  operands
//   op     in  4  6809 low-nibble opcode
//   op7    in  1  disambiguation bit (SUB vs NEG, LD vs ROR)
//   c_in   in  1  carry-in (ADC/SBC), passed through for LD
//   res    out 8  result
//   c      out 1  carry/borrow out
module m6809_alu8
  import m6809_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  input  logic       op7,
  input  logic       c_in,
  output logic [7:0] res,
  output logic       c
);

  logic [8:0] wide;

  always_comb begin
    wide = {1'b0, a};
    res  = a;
    c    = 1'b0;
    case (op)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[7:0];
        c    = wide[8];
      end
      ALU_ADC: begin
        wide = {1'b0, a} + {1'b0, b} + {8'b0, c_in};
        res  = wide[7:0];
        c    = wide[8];
      end
      ALU_SUB: begin
        if (op7) begin
          wide = {1'b0, a} - {1'b0, b};
          res  = wide[7:0];
          c    = wide[8];
        end
      end
      ALU_SBC: begin
        wide = {1'b0, a} - {1'b0, b} - {8'b0, c_in};
        res  = wide[7:0];
        c    = wide[8];
      end
      ALU_LD: begin
        if (op7) begin
          res = b;
          c   = c_in;
        end
      end
      default: begin
        res = a;
        c   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/m6809_alu16_seq.sv
// m6809_alu16_seq: two-pass sequencer for ADDD/SUBD/CMPD(X)/LDD. Drives the
// 8-bit ALU with the low byte first, then the high byte with the carry
// chained, and assembles a registered 16-bit result plus N/Z/V/C.
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   start, op16         request and operation select (sampled in IDLE only)
//   opnd_a, opnd_b      16-bit LHS / RHS, latched on accepted start
//   cc_c_in             current C flag, latched on start, kept by LD
//   alu_a/b/op/op7/c_in operand/opcode drive to the 8-bit ALU
//   alu_res, alu_c      byte result and carry from the ALU
//   result, n/z/v/c_out registered result and flags
//   busy                high in LO and HI
//   done                one-cycle pulse when result/flags update
module m6809_alu16_seq
  import m6809_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op16,
  input  logic [15:0] opnd_a,
  input  logic [15:0] opnd_b,
  input  logic        cc_c_in,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_op7,
  output logic        alu_c_in,
  input  logic [7:0]  alu_res,
  input  logic        alu_c,
  output logic [15:0] result,
  output logic        n_out,
  output logic        z_out,
  output logic        v_out,
  output logic        c_out,
  output logic        busy,
  output logic        done
);

  state_e      state, state_nxt;

  // Holding registers: the operand ports are free to change after start.
  op16_e       h_op;
  logic [15:0] h_a, h_b;
  logic        h_c;

  logic [7:0]  lo_res;
  logic        lo_c, lo_z;

  logic        v_nxt, c_nxt;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_op    = ALU_TST;
    alu_op7   = 1'b0;
    alu_c_in  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LO;
      LO: begin
        alu_a = h_a[7:0];
        alu_b = h_b[7:0];
        case (h_op)
          ALU16_ADD: alu_op = ALU_ADD;
          ALU16_SUB,
          ALU16_CMP: begin alu_op = ALU_SUB; alu_op7 = 1'b1; end
          default:   begin alu_op = ALU_LD;  alu_op7 = 1'b1; alu_c_in = h_c; end
        endcase
        state_nxt = HI;
      end
      HI: begin
        alu_a = h_a[15:8];
        alu_b = h_b[15:8];
        case (h_op)
          ALU16_ADD: begin alu_op = ALU_ADC; alu_op7 = 1'b1; alu_c_in = lo_c; end
          ALU16_SUB,
          ALU16_CMP: begin alu_op = ALU_SBC; alu_c_in = lo_c; end
          default:   begin alu_op = ALU_LD;  alu_op7 = 1'b1; alu_c_in = h_c; end
        endcase
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Overflow is derived from the operand and result sign bits here rather
  // than from the ALU, since the ALU only sees one byte at a time.
  always_comb begin
    v_nxt = 1'b0;
    c_nxt = alu_c;
    case (h_op)
      ALU16_ADD: v_nxt = (h_a[15] == h_b[15]) & (alu_res[7] != h_a[15]);
      ALU16_SUB,
      ALU16_CMP: v_nxt = (h_a[15] != h_b[15]) & (alu_res[7] != h_a[15]);
      default:   begin v_nxt = 1'b0; c_nxt = h_c; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      h_op   <= ALU16_ADD;
      h_a    <= 16'h0000;
      h_b    <= 16'h0000;
      h_c    <= 1'b0;
      lo_res <= 8'h00;
      lo_c   <= 1'b0;
      lo_z   <= 1'b0;
      result <= 16'h0000;
      n_out  <= 1'b0;
      z_out  <= 1'b0;
      v_out  <= 1'b0;
      c_out  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE && start) begin
        h_op <= op16_e'(op16);
        h_a  <= opnd_a;
        h_b  <= opnd_b;
        h_c  <= cc_c_in;
      end
      if (state == LO) begin
        lo_res <= alu_res;
        lo_c   <= alu_c;
        lo_z   <= (alu_res == 8'h00);
      end
      if (state == HI) begin
        n_out <= alu_res[7];
        z_out <= lo_z & (alu_res == 8'h00);
        v_out <= v_nxt;
        c_out <= c_nxt;
        if (h_op != ALU16_CMP) result <= {alu_res, lo_res};
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m6809_alu16_seq.sv
// Bench: sequencer wired to the 8-bit ALU, directed vector table plus
// hand-written sequences for mid-operation start, reset in HI and
// back-to-back operation.
module tb_m6809_alu16_seq;

  logic        clk, reset, start, cc_c_in;
  logic [1:0]  op16;
  logic [15:0] opnd_a, opnd_b, result;
  logic [7:0]  alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic        alu_op7, alu_c_in, alu_c;
  logic        n_out, z_out, v_out, c_out, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  m6809_alu16_seq dut (
    .clk(clk), .reset(reset), .start(start), .op16(op16),
    .opnd_a(opnd_a), .opnd_b(opnd_b), .cc_c_in(cc_c_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_op7(alu_op7),
    .alu_c_in(alu_c_in), .alu_res(alu_res), .alu_c(alu_c),
    .result(result), .n_out(n_out), .z_out(z_out), .v_out(v_out),
    .c_out(c_out), .busy(busy), .done(done)
  );

  m6809_alu8 alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .op7(alu_op7), .c_in(alu_c_in),
    .res(alu_res), .c(alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic [3:0]  nzvc;
  } vec_t;

  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_CMP = 2'd2, OP_LD = 2'd3;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle and follow it to its done cycle.
  task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin,
                        input logic [15:0] res, input logic [3:0] nzvc);
    op16 = op; opnd_a = a; opnd_b = b; cc_c_in = cin; start = 1'b1;
    tick();
    start = 1'b0;
    opnd_a = 16'($urandom); opnd_b = 16'($urandom); op16 = 2'($urandom);
    check({name, " busy/done LO"}, {30'd0, busy, done}, 32'h2);
    tick();
    check({name, " busy/done HI"}, {30'd0, busy, done}, 32'h2);
    tick();
    check({name, " busy/done end"}, {30'd0, busy, done}, 32'h1);
    check({name, " result"}, {16'd0, result}, {16'd0, res});
    check({name, " nzvc"}, {28'd0, n_out, z_out, v_out, c_out}, {28'd0, nzvc});
  endtask

  initial begin
    vt[0]  = '{OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1001};
    vt[1]  = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1010};
    vt[2]  = '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0010};
    vt[3]  = '{OP_ADD, 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 4'b1000};
    vt[4]  = '{OP_CMP, 16'h1234, 16'h1234, 1'b0, 16'hAAAA, 4'b0100};
    vt[5]  = '{OP_LD,  16'h0000, 16'h0000, 1'b1, 16'h0000, 4'b0101};
    vt[6]  = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0101};
    vt[7]  = '{OP_LD,  16'h5555, 16'h8001, 1'b0, 16'h8001, 4'b1000};
    vt[8]  = '{OP_CMP, 16'h0001, 16'h0002, 1'b0, 16'h8001, 4'b1001};
    vt[9]  = '{OP_SUB, 16'h1000, 16'h0FFF, 1'b0, 16'h0001, 4'b0000};
    vt[10] = '{OP_ADD, 16'h00FF, 16'hFF01, 1'b0, 16'h0000, 4'b0101};
    vt[11] = '{OP_SUB, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 4'b0000};
    vt[12] = '{OP_LD,  16'h0000, 16'h1234, 1'b1, 16'h1234, 4'b0001};
    vt[13] = '{OP_CMP, 16'h8000, 16'h0001, 1'b1, 16'h1234, 4'b0010};

    reset = 1'b1; start = 1'b0; op16 = 2'd0;
    opnd_a = 16'h0; opnd_b = 16'h0; cc_c_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset result", {16'd0, result}, 32'h0);
    check("reset flags/busy/done", {26'd0, n_out, z_out, v_out, c_out, busy, done}, 32'h0);
    check("idle alu drive", {15'd0, alu_a, alu_b, alu_op, alu_op7}, {15'd0, 8'h00, 8'h00, 4'hd, 1'b0});

    // ADD 0x12FF + 0x0001, watching both ALU passes.
    op16 = OP_ADD; opnd_a = 16'h12FF; opnd_b = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0; opnd_a = 16'hDEAD; opnd_b = 16'hBEEF;
    check("add LO alu drive", {11'd0, alu_a, alu_b, alu_op, alu_c_in}, {11'd0, 8'hFF, 8'h01, 4'hb, 1'b0});
    check("add LO done", {31'd0, done}, 32'h0);
    tick();
    check("add HI alu drive", {10'd0, alu_a, alu_b, alu_op, alu_op7, alu_c_in},
          {10'd0, 8'h12, 8'h00, 4'h9, 1'b1, 1'b1});
    tick();
    check("add done", {31'd0, done}, 32'h1);
    check("add result", {16'd0, result}, 32'h1300);
    check("add nzvc", {28'd0, n_out, z_out, v_out, c_out}, 32'h0);

    // Table, each op started in the previous op's done cycle.
    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].cin, vt[i].res, vt[i].nzvc);

    // start during LO is ignored.
    tick();
    op16 = OP_ADD; opnd_a = 16'h0001; opnd_b = 16'h0001; start = 1'b1;
    tick();
    op16 = OP_SUB; opnd_a = 16'h5555; opnd_b = 16'h1111;
    tick();
    start = 1'b0;
    tick();
    check("ovl done", {31'd0, done}, 32'h1);
    check("ovl result", {16'd0, result}, 32'h0002);
    tick();
    check("ovl no second op", {30'd0, busy, done}, 32'h0);
    tick();
    check("ovl still idle", {30'd0, busy, done}, 32'h0);

    // Reset in HI drops the operation.
    op16 = OP_SUB; opnd_a = 16'h0000; opnd_b = 16'h0001; cc_c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst busy in HI", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst idle", {30'd0, busy, done}, 32'h0);
    check("rst result", {16'd0, result}, 32'h0);
    check("rst flags", {28'd0, n_out, z_out, v_out, c_out}, 32'h0);
    tick();
    check("rst no done 1", {31'd0, done}, 32'h0);
    tick();
    check("rst no done 2", {31'd0, done}, 32'h0);

    // Recovery after reset.
    run_op("post-rst add", OP_ADD, 16'h0102, 16'h0304, 1'b0, 16'h0406, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
